seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits (range 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (minimum 4).
REQ-003 SHALL have parameter GUARD, default 2, cycles at the start of each slot with all digits off (must be less than SCAN_DIV).
REQ-004 SHALL have port clk, input, 1 bit, single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS bits, hex nibbles; digit 0 = bits [3:0] = rightmost.
REQ-007 SHALL have port blank_mask, input, NUM_DIGITS bits, 1 = force that digit dark.
REQ-008 SHALL have port load, input, 1 bit, one-cycle strobe that captures value and blank_mask into the shadow register.
REQ-009 SHALL have port seg, output, 7 bits, segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port an, output, NUM_DIGITS bits, digit enables, active-low, one-hot or all-high, registered.
REQ-011 SHALL have port frame_tick, output, 1 bit, one-cycle pulse when the active register is updated.

Function
REQ-012 SHALL run a divider div_cnt counting 0..SCAN_DIV-1, then wrapping to 0.
REQ-013 SHALL advance digit_idx by 1 when div_cnt = SCAN_DIV-1, wrapping from NUM_DIGITS-1 to 0.
REQ-014 SHALL copy shadow to the active register on the cycle digit_idx wraps to 0, and pulse frame_tick in that same cycle.
REQ-015 SHALL give load priority on a simultaneous load and wrap: the newly loaded data goes straight to active.
REQ-016 SHALL leave the displayed frame unchanged after a load that is not at a wrap; the load takes effect at the next frame only (no tearing).
REQ-017 SHALL drive an all-high while div_cnt < GUARD.
REQ-018 SHALL otherwise drive an[digit_idx] low, with all other an bits high.
REQ-019 SHALL decode seg from the active nibble of digit_idx using glyphs 0-F, with 0 = 7'b1000000 and F = 7'b0001110 (standard hex font).
REQ-020 SHALL force seg = 7'b1111111 for a digit whose active blank bit is 1, while its an timing is unchanged.
REQ-021 SHALL register seg and an, so they reflect div_cnt and digit_idx with 1 cycle of latency.
REQ-022 SHALL, when NUM_DIGITS = 1, leave digit_idx constant at 0 and wrap every SCAN_DIV cycles.

Reset
REQ-023 SHALL, when rst_n is low, immediately set div_cnt=0, digit_idx=0, shadow=0, active=0, seg=7'b1111111, an all-high and frame_tick=0.
REQ-024 SHALL keep all blank bits at 0 after reset, so the first frame after reset shows all zeros.
REQ-025 SHALL discard shadow contents if reset is asserted mid-frame; there is no partial-frame carry-over.

Configuration
REQ-026 SHALL, with SEG7_LZ_SUPPRESS_EN defined, blank every leading zero digit (highest index downward) up to the first nonzero digit; digit 0 is never suppressed.
REQ-027 SHALL evaluate leading-zero suppression on the active register, ORed with blank_mask.
REQ-028 SHALL, without SEG7_LZ_SUPPRESS_EN, apply only blank_mask, with no extra logic synthesised.

Structure
REQ-029 SHALL place the 16-entry glyph table constants and the SEG_OFF constant (7'b1111111) in shared package seg7_pkg.
REQ-030 SHALL implement the nibble-to-glyph decode in a single combinational sub-module, seg7_hex_dec, instantiated once on the muxed nibble.

Verification
REQ-031 SHALL verify reset: NUM_DIGITS=4, SCAN_DIV=4, GUARD=1, rst_n low -> seg=7'h7F, an=4'hF; release -> first frame shows seg=7'b1000000 on each digit.
REQ-032 SHALL verify scanning: load value=16'h12AF -> after next frame_tick, an cycles E,D,B,7 with seg 0001110, 0001000, 0100100, 1111001; each slot shows 1 guard cycle plus 3 lit cycles.
REQ-033 SHALL verify no tearing: load 16'h1111, then load 16'h2222 mid-frame -> the rest of the frame shows 1s, and 2s appear only after frame_tick.
REQ-034 SHALL verify load-at-wrap: assert load in the wrap cycle with 16'h5555 -> frame_tick and 5s in the very next frame.
REQ-035 SHALL verify blanking: blank_mask=4'b1000 -> digit 3 slot has an=4'h7 and seg=7'h7F.
REQ-036 SHALL verify leading-zero suppression with SEG7_LZ_SUPPRESS_EN: value=16'h0040 -> digits 3 and 2 dark, digit 1 shows 4, digit 0 shows 0; value=16'h0000 -> only digit 0 lit.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared seven-segment constants (active-low {g,f,e,d,c,b,a}).
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Hex font, entry 15 (F) first so GLYPHS[n] is the glyph for nibble n.
    localparam logic [15:0][6:0] GLYPHS = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational nibble-to-glyph decoder.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = GLYPHS[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scanner with shadow/active frame buffering.
// Define SEG7_LZ_SUPPRESS_EN to also blank leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, active_val_q, active_val_d;
    logic [NUM_DIGITS-1:0]   shadow_blk_q, shadow_blk_d, active_blk_q, active_blk_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_tick_q, frame_tick_d;
    logic                    slot_end, wrap;
    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   blank_eff;

    assign slot_end = div_cnt_q == DIV_LAST;
    assign wrap     = slot_end && digit_idx_q == IDX_LAST;
    assign nib      = active_val_q[{digit_idx_q, 2'b00} +: 4];

    seg7_hex_dec u_dec (
        .nib_i (nib),
        .seg_o (glyph)
    );

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [NUM_DIGITS-1:0] lz;
    logic                  lz_run;

    // Walk down from the top digit; digit 0 is never part of the run.
    always_comb begin
        lz     = '0;
        lz_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run = lz_run && active_val_q[4*i +: 4] == 4'h0;
            lz[i]  = lz_run;
        end
    end

    assign blank_eff = active_blk_q | lz;
`else
    assign blank_eff = active_blk_q;
`endif

    // Shadow-next feeds active at the wrap, which gives a coincident load priority.
    always_comb begin
        div_cnt_d    = slot_end ? '0 : div_cnt_q + DIV_W'(1);
        digit_idx_d  = !slot_end ? digit_idx_q : (digit_idx_q == IDX_LAST ? '0 : digit_idx_q + IDX_W'(1));
        shadow_val_d = load ? value : shadow_val_q;
        shadow_blk_d = load ? blank_mask : shadow_blk_q;
        active_val_d = wrap ? shadow_val_d : active_val_q;
        active_blk_d = wrap ? shadow_blk_d : active_blk_q;
        frame_tick_d = wrap;
        seg_d        = blank_eff[digit_idx_q] ? SEG_OFF : glyph;
        an_d         = div_cnt_q < DIV_W'(GUARD) ? '1 : ~(NUM_DIGITS'(1) << digit_idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            digit_idx_q  <= '0;
            shadow_val_q <= '0;
            shadow_blk_q <= '0;
            active_val_q <= '0;
            active_blk_q <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_blk_q <= shadow_blk_d;
            active_val_q <= active_val_d;
            active_blk_q <= active_blk_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scenario tasks plus a frame-level reference model.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * SD;
    localparam logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    logic rst_n;
    logic [15:0] value;
    logic [3:0] blank_mask;
    logic load;
    logic [6:0] seg;
    logic [3:0] an;
    logic frame_tick;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD(GD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .blank_mask(blank_mask),
        .load(load), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    function automatic logic dark(input logic [15:0] v, input logic [3:0] b, input int d);
        logic z;
        z = 1'b1;
        if (b[d]) return 1'b1;
`ifdef SEG7_LZ_SUPPRESS_EN
        if (d > 0) begin
            for (int j = d; j < ND; j++) if (v[4*j +: 4] != 4'h0) z = 1'b0;
            return z;
        end
`endif
        return 1'b0;
    endfunction

    // Reference: pos is the time within the frame; outputs show the previous pos.
    int pos;
    logic [15:0] m_sh, m_act;
    logic [3:0] m_shb, m_actb;
    logic [6:0] exp_seg;
    logic [3:0] exp_an;
    logic exp_tick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 0; m_sh <= '0; m_shb <= '0; m_act <= '0; m_actb <= '0;
            exp_seg <= 7'h7F; exp_an <= 4'hF; exp_tick <= 1'b0;
        end else begin
            exp_an   <= (pos % SD < GD) ? 4'hF : ~(4'(1) << (pos / SD));
            exp_seg  <= dark(m_act, m_actb, pos / SD) ? 7'h7F : FONT[m_act[4*(pos/SD) +: 4]];
            exp_tick <= pos == FRAME - 1;
            if (load) begin m_sh <= value; m_shb <= blank_mask; end
            if (pos == FRAME - 1) begin
                m_act  <= load ? value : m_sh;
                m_actb <= load ? blank_mask : m_shb;
            end
            pos <= (pos + 1) % FRAME;
        end
    end

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4 * FRAME && !ok; i++) begin
            @(negedge clk);
            ok = frame_tick;
        end
    endtask

    task automatic pulse_load(input logic [15:0] v, input logic [3:0] b);
        value = v; blank_mask = b; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load = 1'b0; value = '0; blank_mask = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({seg, an, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++; $display("FAIL reset_hold seg=%h an=%h tick=%b expected 7f f 0", seg, an, frame_tick);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_tick}) begin
                errors++; $display("FAIL reset_model seg=%h an=%h tick=%b expected %h %h %b", seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h40) begin errors++; $display("FAIL first_frame_zero seg=%h expected 40", seg); end
            end
        end
        pulse_load(16'h9999, 4'h0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 checks++;
        if ({seg, an, frame_tick} !== {7'h7F, 4'hF, 1'b0}) begin
            errors++; $display("FAIL async_reset seg=%h an=%h tick=%b expected 7f f 0", seg, an, frame_tick);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h40) begin errors++; $display("FAIL shadow_discard seg=%h expected 40", seg); end
            end
        end
    endtask

    task automatic test_scanning();
        logic [3:0] an_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] seg_tab [4] = '{7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001};
        bit ok;
        wait_tick(ok);
        pulse_load(16'h12AF, 4'h0);
        wait_tick(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL scan_tick_timeout got=0 expected=1"); end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if (an !== ((c % SD == 0) ? 4'hF : an_tab[c / SD])) begin
                errors++; $display("FAIL scan_an cycle=%0d an=%h expected %h", c, an, (c % SD == 0) ? 4'hF : an_tab[c / SD]);
            end
            if (c % SD != 0) begin
                checks++;
                if (seg !== seg_tab[c / SD]) begin
                    errors++; $display("FAIL scan_seg cycle=%0d seg=%b expected %b", c, seg, seg_tab[c / SD]);
                end
            end
        end
    endtask

    task automatic test_no_tearing();
        bit ok;
        bit got;
        wait_tick(ok);
        pulse_load(16'h1111, 4'h0);
        wait_tick(ok);
        repeat (4) @(negedge clk);
        pulse_load(16'h2222, 4'h0);
        got = 1'b0;
        for (int c = 0; c < 2 * FRAME && !got; c++) begin
            @(negedge clk);
            got = frame_tick;
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h79) begin errors++; $display("FAIL tearing_old seg=%h expected 79", seg); end
            end
        end
        checks++;
        if (!got) begin errors++; $display("FAIL tearing_tick_timeout got=0 expected=1"); end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h24) begin errors++; $display("FAIL tearing_new seg=%h expected 24", seg); end
            end
        end
    endtask

    task automatic test_load_at_wrap();
        bit ok;
        wait_tick(ok);
        repeat (FRAME - 1) @(negedge clk);
        value = 16'h5555; blank_mask = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        checks++;
        if (frame_tick !== 1'b1) begin errors++; $display("FAIL wrap_tick got=%b expected 1", frame_tick); end
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (an !== 4'hF) begin
                checks++;
                if (seg !== 7'h12) begin errors++; $display("FAIL wrap_data seg=%h expected 12", seg); end
            end
        end
    endtask

    task automatic test_blanking();
        bit ok;
        wait_tick(ok);
        pulse_load(16'($urandom), 4'b1000);
        wait_tick(ok);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, an} !== {exp_seg, exp_an}) begin
                errors++; $display("FAIL blank_model seg=%h an=%h expected %h %h", seg, an, exp_seg, exp_an);
            end
            if (c / SD == 3 && c % SD != 0) begin
                checks++;
                if ({an, seg} !== {4'h7, 7'h7F}) begin
                    errors++; $display("FAIL blank_digit3 an=%h seg=%h expected 7 7f", an, seg);
                end
            end
        end
        pulse_load(16'h0000, 4'h0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if ({seg, an, frame_tick} !== {exp_seg, exp_an, exp_tick}) begin
                errors++; $display("FAIL random_model cycle=%0d seg=%h an=%h tick=%b expected %h %h %b", c, seg, an, frame_tick, exp_seg, exp_an, exp_tick);
            end
            load = ($urandom_range(3) == 0);
            value = 16'($urandom);
            blank_mask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
        end
        load = 1'b0;
    endtask

`ifdef SEG7_LZ_SUPPRESS_EN
    task automatic test_lz();
        logic [6:0] t40 [4] = '{7'h40, 7'h19, 7'h7F, 7'h7F};
        logic [6:0] t00 [4] = '{7'h40, 7'h7F, 7'h7F, 7'h7F};
        bit ok;
        for (int p = 0; p < 2; p++) begin
            wait_tick(ok);
            pulse_load(p == 0 ? 16'h0040 : 16'h0000, 4'h0);
            wait_tick(ok);
            for (int c = 0; c < FRAME; c++) begin
                @(negedge clk);
                if (c % SD != 0) begin
                    checks++;
                    if (seg !== (p == 0 ? t40[c / SD] : t00[c / SD])) begin
                        errors++; $display("FAIL lz pass=%0d digit=%0d seg=%h expected %h", p, c / SD, seg, p == 0 ? t40[c / SD] : t00[c / SD]);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scanning();
        test_no_tearing();
        test_load_at_wrap();
        test_blanking();
        test_random();
`ifdef SEG7_LZ_SUPPRESS_EN
        test_lz();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule
